// File: rtl/input_sanitizer_mc.sv
// input_sanitizer_mc: multi-channel pad-input sanitizer.
//   Per channel: N-sample stability debounce with accepted-edge pulses and
//   toggle-rate (fuzz) detection over a free-running window. Any channel
//   reaching the toggle threshold starts a global timed lockout that freezes
//   the debounced outputs and ignores input activity.
// Interface: no handshake. Every output is registered and meaningful on
//   every cycle; rise/fall/attack_pulse are single-cycle pulses.
// Lockout FSM state is visible directly on the 'locked' output.
// Build option: define SANITIZER_SYNC_EN to insert a 2-flop synchroniser per
//   channel ahead of the sampling point (adds 2 cycles to all latencies).
module input_sanitizer_mc #(
  parameter int WIDTH            = 8,
  parameter int DEBOUNCE_CYCLES  = 4,
  parameter int ATTACK_WINDOW    = 100,
  parameter int ATTACK_THRESHOLD = 10,
  parameter int LOCKOUT_CYCLES   = 25_000_000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] signal_in,
  output logic [WIDTH-1:0] signal_out,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall,
  output logic             locked,
  output logic             attack_pulse,
  output logic [WIDTH-1:0] attack_src,
  output logic [7:0]       attack_cnt
);

  localparam int DW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int WW = $clog2(ATTACK_WINDOW);
  localparam int CW = $clog2(ATTACK_THRESHOLD);
  localparam int LW = (LOCKOUT_CYCLES > 1) ? $clog2(LOCKOUT_CYCLES) : 1;

  localparam logic [DW-1:0] D_LAST = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [WW-1:0] W_LAST = WW'(ATTACK_WINDOW - 1);
  localparam logic [CW-1:0] C_LAST = CW'(ATTACK_THRESHOLD - 1);
  localparam logic [LW-1:0] L_LAST = LW'(LOCKOUT_CYCLES - 1);

  typedef enum logic {ST_RUN = 1'b0, ST_LOCK = 1'b1} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] s;
  logic [WIDTH-1:0] prev;
  logic [WIDTH-1:0] toggle;
  logic [WIDTH-1:0] trip_vec;
  logic [DW-1:0]    dcnt [WIDTH];
  logic [CW-1:0]    ccnt [WIDTH];
  logic [WW-1:0]    wcnt;
  logic [LW-1:0]    lcnt;
  logic             wrap;
  logic             any_trip;
  logic             lock_done;

`ifdef SANITIZER_SYNC_EN
  logic [WIDTH-1:0] sync1, sync2;

  // Two-flop synchroniser; keeps running through lockout so the first
  // post-lockout sample is current.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= signal_in;
      sync2 <= sync1;
    end
  end

  assign s = sync2;
`else
  assign s = signal_in;
`endif

  assign locked = (state == ST_LOCK);

  // Trip detection uses the pre-clear toggle count, so a trip on the window
  // wrap cycle is still seen.
  always_comb begin
    toggle   = s ^ prev;
    trip_vec = '0;
    for (int i = 0; i < WIDTH; i++) begin
      trip_vec[i] = (state == ST_RUN) && toggle[i] && (ccnt[i] == C_LAST);
    end
    any_trip  = |trip_vec;
    wrap      = (wcnt == W_LAST);
    lock_done = (state == ST_LOCK) && (lcnt == L_LAST);
  end

  // Lockout FSM next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_RUN:  if (any_trip)  state_nxt = ST_LOCK;
      ST_LOCK: if (lock_done) state_nxt = ST_RUN;
      default: state_nxt = ST_RUN;
    endcase
  end

  // Lockout FSM state register; async reset aborts a lockout immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_RUN;
    else        state <= state_nxt;
  end

  // Lockout timer and attack event reporting.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lcnt         <= '0;
      attack_pulse <= 1'b0;
      attack_src   <= '0;
      attack_cnt   <= '0;
    end else begin
      attack_pulse <= any_trip;
      if (any_trip) begin
        attack_src <= trip_vec;
        lcnt       <= '0;
        if (attack_cnt != 8'hFF) attack_cnt <= attack_cnt + 8'd1;
      end else if (state == ST_LOCK) begin
        lcnt <= lock_done ? '0 : lcnt + LW'(1);
      end
    end
  end

  // Fuzz detection: previous sample, window position and per-channel toggle
  // counts. All held at zero while locked; prev reloads on lockout exit so
  // the first unlocked cycle does not see a stale toggle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev <= '0;
      wcnt <= '0;
      for (int i = 0; i < WIDTH; i++) ccnt[i] <= '0;
    end else if (state == ST_LOCK) begin
      wcnt <= '0;
      for (int i = 0; i < WIDTH; i++) ccnt[i] <= '0;
      if (lock_done) prev <= s;
    end else if (any_trip) begin
      prev <= s;
      wcnt <= '0;
      for (int i = 0; i < WIDTH; i++) ccnt[i] <= '0;
    end else begin
      prev <= s;
      wcnt <= wrap ? '0 : wcnt + WW'(1);
      for (int i = 0; i < WIDTH; i++) begin
        if (wrap) ccnt[i] <= CW'(toggle[i]);
        else if (toggle[i] && (ccnt[i] != C_LAST)) ccnt[i] <= ccnt[i] + CW'(1);
      end
    end
  end

  // Per-channel debounce; outputs and edge pulses frozen on the trip cycle
  // and throughout lockout.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      signal_out <= '0;
      rise       <= '0;
      fall       <= '0;
      for (int i = 0; i < WIDTH; i++) dcnt[i] <= '0;
    end else begin
      rise <= '0;
      fall <= '0;
      if ((state == ST_LOCK) || any_trip) begin
        for (int i = 0; i < WIDTH; i++) dcnt[i] <= '0;
      end else begin
        for (int i = 0; i < WIDTH; i++) begin
          if (s[i] == signal_out[i]) begin
            dcnt[i] <= '0;
          end else if (dcnt[i] == D_LAST) begin
            signal_out[i] <= s[i];
            dcnt[i]       <= '0;
            rise[i]       <= s[i];
            fall[i]       <= ~s[i];
          end else begin
            dcnt[i] <= dcnt[i] + DW'(1);
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_input_sanitizer_mc.sv
// Testbench for input_sanitizer_mc: directed scenarios plus randomized
// traffic, all checked cycle-by-cycle through an expected-output queue fed
// by a behavioural reference model. Works with or without SANITIZER_SYNC_EN.
module tb_input_sanitizer_mc;

  localparam int WIDTH = 8;
  localparam int DEB   = 4;
  localparam int WIN   = 100;
  localparam int TH    = 10;
  localparam int LOCK  = 50;
`ifdef SANITIZER_SYNC_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 0;
`endif
  localparam int OW = 4 * WIDTH + 2 + 8;

  // ---------------- clock / reset ----------------
  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [WIDTH-1:0] signal_in = '0;
  logic [WIDTH-1:0] signal_out, rise, fall, attack_src;
  logic             locked, attack_pulse;
  logic [7:0]       attack_cnt;

  always #5 clk = ~clk;

  input_sanitizer_mc #(
    .WIDTH(WIDTH), .DEBOUNCE_CYCLES(DEB), .ATTACK_WINDOW(WIN),
    .ATTACK_THRESHOLD(TH), .LOCKOUT_CYCLES(LOCK)
  ) dut (
    .clk(clk), .rst_n(rst_n), .signal_in(signal_in),
    .signal_out(signal_out), .rise(rise), .fall(fall),
    .locked(locked), .attack_pulse(attack_pulse),
    .attack_src(attack_src), .attack_cnt(attack_cnt)
  );

  int checks = 0;
  int errors = 0;
  logic [OW-1:0] exp_q[$];

  // ---------------- reference model ----------------
  // Behavioural view: a channel accepts a level after DEB consecutive
  // samples disagreeing with it; toggles are counted per window of WIN
  // cycles measured from the last unlock; the TH-th toggle in a window locks
  // everything for LOCK cycles.
  logic [WIDTH-1:0] m_out, m_prev, m_src, m_sy1, m_sy2, m_rise, m_fall;
  bit               m_locked, m_pulse;
  int               m_cnt, m_elapsed, m_pos;
  int               m_tog[WIDTH];
  int               m_streak[WIDTH];

  function automatic void model_reset();
    m_out = '0; m_prev = '0; m_src = '0; m_sy1 = '0; m_sy2 = '0;
    m_rise = '0; m_fall = '0; m_locked = 0; m_pulse = 0;
    m_cnt = 0; m_elapsed = 0; m_pos = 0;
    for (int i = 0; i < WIDTH; i++) begin
      m_tog[i] = 0;
      m_streak[i] = 0;
    end
  endfunction

  function automatic void model_clear_history();
    m_pos = 0;
    for (int i = 0; i < WIDTH; i++) begin
      m_tog[i] = 0;
      m_streak[i] = 0;
    end
  endfunction

  function automatic void model_step(input logic [WIDTH-1:0] v);
    logic [WIDTH-1:0] smp, trips;
    bit t;
`ifdef SANITIZER_SYNC_EN
    smp = m_sy2;
`else
    smp = v;
`endif
    m_sy2 = m_sy1;
    m_sy1 = v;
    m_rise = '0; m_fall = '0; m_pulse = 0;
    if (m_locked) begin
      m_elapsed++;
      if (m_elapsed == LOCK) begin
        m_locked = 0;
        m_prev = smp;
        model_clear_history();
      end
    end else begin
      trips = '0;
      for (int i = 0; i < WIDTH; i++) begin
        t = (smp[i] != m_prev[i]);
        if (t && m_tog[i] == TH - 1) trips[i] = 1'b1;
        if (m_pos == WIN - 1) m_tog[i] = int'(t);
        else m_tog[i] += int'(t);
      end
      m_prev = smp;
      m_pos = (m_pos + 1) % WIN;
      if (trips != '0) begin
        m_locked = 1; m_pulse = 1; m_src = trips; m_elapsed = 0;
        if (m_cnt < 255) m_cnt++;
        model_clear_history();
      end else begin
        for (int i = 0; i < WIDTH; i++) begin
          if (smp[i] == m_out[i]) m_streak[i] = 0;
          else begin
            m_streak[i]++;
            if (m_streak[i] == DEB) begin
              m_out[i] = smp[i];
              m_streak[i] = 0;
              if (smp[i]) m_rise[i] = 1'b1;
              else        m_fall[i] = 1'b1;
            end
          end
        end
      end
    end
  endfunction

  function automatic logic [OW-1:0] pack_model();
    return {m_out, m_rise, m_fall, m_locked, m_pulse, m_src, 8'(m_cnt)};
  endfunction

  function automatic logic [OW-1:0] pack_dut();
    return {signal_out, rise, fall, locked, attack_pulse, attack_src, attack_cnt};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic drive(input logic [WIDTH-1:0] v);
    @(negedge clk);
    signal_in = v;
    model_step(v);
    exp_q.push_back(pack_model());
  endtask

  task automatic settle();
    @(posedge clk);
    #1;
  endtask

  task automatic release_reset();
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    signal_in = '0;
    model_reset();
    release_reset();
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [WIDTH-1:0] t4_pat(input int n);
    logic [WIDTH-1:0] v;
    v = '0;
    if (n >= 90 && n <= 98)        v[2] = ((n - 90) % 2 == 0);
    else if (n == 99)              v[2] = 1'b1;
    else if (n >= 100 && n <= 108) v[2] = ((n - 100) % 2 == 1);
    if (n >= 110 && n <= 119) begin
      v[4] = ((n - 110) % 2 == 0);
      v[6] = v[4];
    end
    return v;
  endfunction

  // ---------------- scoreboard monitor ----------------
  initial begin
    logic [OW-1:0] exp;
    forever begin
      @(posedge clk);
      #1;
      if (rst_n && exp_q.size() > 0) begin
        exp = exp_q.pop_front();
        checks++;
        if (pack_dut() !== exp) begin
          errors++;
          $display("FAIL scoreboard t=%0t: dut=%h expected=%h", $time, pack_dut(), exp);
        end
      end
    end
  end

  // ---------------- watchdog ----------------
  initial begin
    #5_000_000;
    errors++;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "watchdog expired");
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [WIDTH-1:0] v, frozen;
    int budget;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("reset_state", 64'(pack_dut()), 64'd0);
    #1 rst_n = 1'b1;

    // 1: single-channel debounce and short glitch rejection
    repeat (5) drive('0);
    for (int j = 0; j < 4 + LAT; j++) begin
      drive(8'h01);
      settle();
      if (j == 2 + LAT) chk("t1_before_accept", 64'(signal_out[0]), 64'd0);
    end
    chk("t1_accept", 64'(signal_out[0]), 64'd1);
    chk("t1_rise", 64'(rise[0]), 64'd1);
    drive(8'h01);
    settle();
    chk("t1_rise_one_cycle", 64'(rise[0]), 64'd0);
    repeat (4 + LAT + 2) drive('0);
    settle();
    chk("t1_fall_back", 64'(signal_out[0]), 64'd0);
    for (int j = 0; j < 3; j++) begin
      drive(8'h01);
      settle();
      chk("t1_glitch_no_rise", 64'(rise[0]), 64'd0);
    end
    for (int j = 0; j < 6; j++) begin
      drive('0);
      settle();
      chk("t1_glitch_dropped", 64'(signal_out[0]), 64'd0);
    end

    // 2: ch1 and ch5 rise together, ch5 glitches on its second sample
    for (int j = 0; j < 6 + LAT; j++) begin
      v = 8'h02;
      v[5] = (j != 1);
      drive(v);
      settle();
      if (j == 2 + LAT) chk("t2_ch1_early", 64'(signal_out[1]), 64'd0);
      if (j == 3 + LAT) chk("t2_ch1_accept", 64'(signal_out[1]), 64'd1);
      if (j == 4 + LAT) chk("t2_ch5_early", 64'(signal_out[5]), 64'd0);
      if (j == 5 + LAT) chk("t2_ch5_accept", 64'(signal_out[5]), 64'd1);
    end

    // 3: ch3 toggling every cycle trips on its 10th toggle
    do_reset();
    for (int j = 0; j < 10 + LAT; j++) begin
      drive((j % 2 == 0) ? 8'h08 : 8'h00);
      settle();
      if (j == 8 + LAT) chk("t3_not_yet_locked", 64'(locked), 64'd0);
    end
    chk("t3_locked", 64'(locked), 64'd1);
    chk("t3_attack_pulse", 64'(attack_pulse), 64'd1);
    chk("t3_attack_src", 64'(attack_src), 64'h08);
    chk("t3_attack_cnt", 64'(attack_cnt), 64'd1);
    frozen = signal_out;

    // 5: lockout ignores input activity and lasts exactly LOCK cycles
    for (int j = 1; j <= LOCK; j++) begin
      drive(WIDTH'($urandom));
      settle();
      if (j == 1) chk("t5_pulse_single", 64'(attack_pulse), 64'd0);
      chk("t5_frozen", 64'(signal_out), 64'(frozen));
      chk("t5_no_edges", 64'(rise | fall), 64'd0);
      if (j == LOCK - 1) chk("t5_still_locked", 64'(locked), 64'd1);
      if (j == LOCK)     chk("t5_unlocked", 64'(locked), 64'd0);
    end
    chk("t5_src_sticky", 64'(attack_src), 64'h08);
    repeat (4 + LAT) drive(8'hA5);
    settle();
    chk("t5_debounce_resumes", 64'(signal_out), 64'hA5);

    // 4: window wrap splits toggles; two channels trip in one cycle
    do_reset();
    for (int j = 0; j < 120; j++) begin
      drive(t4_pat(j + LAT));
      settle();
      if (j == 118) chk("t4_no_lock_across_wrap", 64'(locked), 64'd0);
    end
    chk("t4_locked", 64'(locked), 64'd1);
    chk("t4_attack_src_two", 64'(attack_src), 64'h50);
    chk("t4_attack_cnt_one", 64'(attack_cnt), 64'd1);

    // 5 (cont.): asynchronous reset in the middle of a lockout
    repeat (10) drive(WIDTH'($urandom));
    settle();
    #2 rst_n = 1'b0;
    #1 chk("t5_async_reset_outputs", 64'(pack_dut()), 64'd0);
    signal_in = '0;
    model_reset();
    release_reset();

    // randomized traffic: alternating calm and bursty phases
    v = '0;
    for (int j = 0; j < 3000; j++) begin
      int rate;
      logic [WIDTH-1:0] mask;
      rate = ((j / 200) % 2 == 0) ? 12 : 2;
      mask = '0;
      for (int i = 0; i < WIDTH; i++) mask[i] = ($urandom_range(rate - 1) == 0);
      v = v ^ mask;
      drive(v);
    end

    // 6: force 260 trips; the event counter must saturate at 255
    for (int t = 0; t < 260; t++) begin
      budget = 0;
      while (m_locked && budget < LOCK + 5) begin
        drive(v);
        budget++;
      end
      budget = 0;
      while (!m_locked && budget < 3 * TH + LAT + 5) begin
        v = v ^ 8'h01;
        drive(v);
        budget++;
      end
      if (!m_locked) begin
        checks++;
        errors++;
        $display("FAIL sat_trip_timeout: trip %0d not reached within %0d cycles", t, budget);
        break;
      end
    end
    settle();
    chk("t6_attack_cnt_saturated", 64'(attack_cnt), 64'd255);

    repeat (5) drive(v);
    repeat (3) @(posedge clk);
    #2;
    chk("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
